inst_decoder: RTL and testbench
===============================

INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 Parameter BURST_LEN, default 8: required beat count of every write burst.
REQ-002 Parameter ADDR_W, default 4: width of the qk and p address fields.
REQ-003 clk  input  1: single clock; all state updates on posedge.
REQ-004 reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 inst  input  19: instruction word, negedge-launched by the sequencer. Bit fields:
- [18] div, [17] acc, [16] ofifo_rd
- [15:12] qkmem_add, [11:8] pmem_add
- [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
REQ-006 qmem_cen, qmem_wen, kmem_cen, kmem_wen, pmem_cen, pmem_wen  output  1 each: active-low SRAM strobes.
REQ-007 qk_addr  output  ADDR_W: registered qkmem_add.
REQ-008 p_addr  output  ADDR_W: registered pmem_add.
REQ-009 l0_wr, mac_exec, ofifo_rd_o, sfp_acc, sfp_div  output  1 each: registered core controls.
REQ-010 burst_done  output  1: one-cycle pulse at the end of any q/k/p burst.
REQ-011 burst_type  output  3: type of the burst just ended: QW=1, KW=2, KR=3, QR=4, PW=5, PR=6; valid with burst_done.
REQ-012 burst_beats  output  5: beat count of the burst just ended; valid with burst_done.
REQ-013 err  output  3: sticky error flags: [0] CONFLICT, [1] ADDR, [2] LEN.

Function
REQ-014 inst SHALL be sampled every posedge; all outputs are registered, 1-cycle latency from sample.
REQ-015 Strobe mapping:
- xmem_cen = !(x_rd | x_wr)
- xmem_wen = !x_wr
- l0_wr = load, mac_exec = execute, ofifo_rd_o = ofifo_rd, sfp_acc = acc, sfp_div = div
REQ-016 Burst: maximal run of consecutive sampled cycles with a given rd or wr bit high; a separate tracker runs for each of the 6 types.
REQ-017 Burst start: first beat address SHALL be 0; otherwise set err[1].
REQ-018 Addresses: each later beat SHALL equal previous+1 mod 2^ADDR_W; otherwise set err[1].
- Wrap from 15 to 0 is legal.
- Check uses qkmem_add for Q/K bursts and pmem_add for P bursts.
REQ-019 Burst end: first sampled cycle with the bit low. In the following cycle, burst_done=1 with burst_type and burst_beats (saturating at 31).
REQ-020 Length check: QW, KW or PW bursts with beats != BURST_LEN SHALL set err[2]; read bursts are not length-checked.
REQ-021 Conflict: x_rd & x_wr high in the same sample, for any x in {q,k,p}, SHALL set err[0].
- The conflicting cycle drives cen=0, wen=1 (read wins).
- The tracker treats that cycle as a write beat.
REQ-022 Simultaneous burst ends: if two ends fall in one cycle, report the lower type code first and the other in the next cycle; at most one pending report is queued per type.
REQ-023 err bits SHALL remain set until reset; no other clear path.
REQ-024 Idle (all bits 0): cen=wen=1, controls 0, no pulses.

Reset
REQ-025 On reset=0, immediately and asynchronously:
- all cen/wen = 1
- addresses, controls, burst_done, burst_type, burst_beats, err = 0
- trackers idle, pending queue empty
REQ-026 Reset mid-burst SHALL abort the burst with no burst_done and no LEN error. The first high sample after release starts a new burst.

Structure
REQ-027 A shared package SHALL hold:
- inst bit-position constants
- burst_type codes
- err bit indices
- INST_W=19
REQ-028 One sub-module, burst_tracker, SHALL be instantiated 6 times. Each instance holds active, beat counter, expected address, addr_err and done/len outputs.

Verification
REQ-029 8 cycles qmem_wr=1, qkmem_add 0..7, then 0 -> qmem_cen=qmem_wen=0 for 8 cycles lagging 1 cycle; burst_done with type=1, beats=8; err=0.
REQ-030 kmem_wr burst of 7 beats -> burst_done type=2, beats=7; err[2]=1 and stays set.
REQ-031 qmem_rd burst with addresses 0,1,3 -> err[1]=1 at the third beat; no LEN error.
REQ-032 pmem_rd=pmem_wr=1 for one cycle -> err[0]=1; pmem_cen=0, pmem_wen=1 that cycle.
REQ-033 reset=0 asserted mid-PW burst at beat 4 -> outputs reset immediately; no burst_done; err=0; a new 8-beat PW burst after release completes cleanly.
REQ-034 qmem_rd and kmem_rd both end in the same cycle -> burst_done type=3, then type=4 on the next cycle.

Source files
------------

// File: rtl/inst_decoder_pkg.sv
// Shared constants for the instruction decoder: inst field positions, burst type codes, err bit indices.
package inst_decoder_pkg;

  localparam int INST_W    = 19;
  localparam int NUM_TYPES = 6;

  localparam int B_DIV      = 18;
  localparam int B_ACC      = 17;
  localparam int B_OFIFO_RD = 16;
  localparam int B_QK_ADD   = 12;
  localparam int B_P_ADD    = 8;
  localparam int B_EXECUTE  = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_QMEM_WR  = 4;
  localparam int B_KMEM_RD  = 3;
  localparam int B_KMEM_WR  = 2;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_QW   = 3'd1,
    BT_KW   = 3'd2,
    BT_KR   = 3'd3,
    BT_QR   = 3'd4,
    BT_PW   = 3'd5,
    BT_PR   = 3'd6
  } burst_type_e;

  localparam int ERR_CONFLICT = 0;
  localparam int ERR_ADDR     = 1;
  localparam int ERR_LEN      = 2;

  // Tracker index i reports type code i+1; write trackers are length-checked, PW/PR follow pmem_add.
  localparam logic [NUM_TYPES-1:0] LEN_CHECK_MASK = 6'b010011;
  localparam logic [NUM_TYPES-1:0] P_ADDR_MASK    = 6'b110000;

  function automatic burst_type_e type_code(input int idx);
    return burst_type_e'(3'(idx + 1));
  endfunction

endpackage

// File: rtl/inst_decoder_if.sv
// Sequencer <-> decoder bundle: instruction word in, SRAM strobes, core controls and burst reports out.
interface inst_decoder_if #(parameter int ADDR_W = 4);

  logic [inst_decoder_pkg::INST_W-1:0] inst;
  logic              qmem_cen, qmem_wen, kmem_cen, kmem_wen, pmem_cen, pmem_wen;
  logic [ADDR_W-1:0] qk_addr, p_addr;
  logic              l0_wr, mac_exec, ofifo_rd_o, sfp_acc, sfp_div;
  logic              burst_done;
  logic [2:0]        burst_type;
  logic [4:0]        burst_beats;
  logic [2:0]        err;

  modport master (
    output inst,
    input  qmem_cen, qmem_wen, kmem_cen, kmem_wen, pmem_cen, pmem_wen,
    input  qk_addr, p_addr, l0_wr, mac_exec, ofifo_rd_o, sfp_acc, sfp_div,
    input  burst_done, burst_type, burst_beats, err
  );

  modport slave (
    input  inst,
    output qmem_cen, qmem_wen, kmem_cen, kmem_wen, pmem_cen, pmem_wen,
    output qk_addr, p_addr, l0_wr, mac_exec, ofifo_rd_o, sfp_acc, sfp_div,
    output burst_done, burst_type, burst_beats, err
  );

endinterface

// File: rtl/burst_tracker.sv
// One burst type: counts beats, checks address sequence; end/len/addr flags are combinational off the sample.
// Latency: flags valid in the sampling cycle; no backpressure.
module burst_tracker #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 4,
  parameter bit CHECK_LEN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [4:0]        beats_out,
  output logic              addr_err,
  output logic              len_err
);

  logic              active;
  logic [4:0]        beats;
  logic [ADDR_W-1:0] exp_addr;

  assign done      = active & ~beat;
  assign beats_out = beats;
  assign addr_err  = beat & (active ? (addr != exp_addr) : (addr != '0));
  assign len_err   = CHECK_LEN & done & (beats != 5'(BURST_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      beats    <= '0;
      exp_addr <= '0;
    end else if (beat) begin
      active   <= 1'b1;
      // Counter saturates so very long read bursts still report 31.
      beats    <= !active ? 5'd1 : ((beats == 5'd31) ? beats : beats + 5'd1);
      exp_addr <= addr + 1'b1;
    end else begin
      active   <= 1'b0;
      beats    <= '0;
    end
  end

endmodule

// File: rtl/inst_decoder.sv
// Decodes the sequencer instruction word into SRAM strobes and core controls, tracking q/k/p bursts.
// Latency: 1 cycle from sample for every output; no backpressure (simultaneous burst reports queue by type).
module inst_decoder
  import inst_decoder_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  inst_decoder_if.slave  bus
);

  logic [INST_W-1:0] inst;
  logic              q_rd, q_wr, k_rd, k_wr, p_rd, p_wr;
  logic [ADDR_W-1:0] qk_add, p_add;

  assign inst   = bus.inst;
  assign q_rd   = inst[B_QMEM_RD];
  assign q_wr   = inst[B_QMEM_WR];
  assign k_rd   = inst[B_KMEM_RD];
  assign k_wr   = inst[B_KMEM_WR];
  assign p_rd   = inst[B_PMEM_RD];
  assign p_wr   = inst[B_PMEM_WR];
  assign qk_add = inst[B_QK_ADD +: ADDR_W];
  assign p_add  = inst[B_P_ADD +: ADDR_W];

  logic [NUM_TYPES-1:0] beat_vec, end_vec, aerr_vec, lerr_vec;
  logic [4:0]           end_beats [NUM_TYPES];
  logic                 conflict;

  // A conflicting cycle counts as a write beat only; the read tracker never sees it.
  assign beat_vec = {p_rd & ~p_wr, p_wr, q_rd & ~q_wr, k_rd & ~k_wr, k_wr, q_wr};
  assign conflict = (q_rd & q_wr) | (k_rd & k_wr) | (p_rd & p_wr);

  for (genvar i = 0; i < NUM_TYPES; i++) begin : g_trk
    burst_tracker #(
      .BURST_LEN (BURST_LEN),
      .ADDR_W    (ADDR_W),
      .CHECK_LEN (LEN_CHECK_MASK[i])
    ) u_trk (
      .clk       (clk),
      .reset     (reset),
      .beat      (beat_vec[i]),
      .addr      (P_ADDR_MASK[i] ? p_add : qk_add),
      .done      (end_vec[i]),
      .beats_out (end_beats[i]),
      .addr_err  (aerr_vec[i]),
      .len_err   (lerr_vec[i])
    );
  end

  logic [NUM_TYPES-1:0] pend, pend_nxt, merged, rpt_onehot;
  logic [4:0]           pend_beats [NUM_TYPES];
  logic                 rpt_vld;
  burst_type_e          rpt_type;
  logic [4:0]           rpt_beats;
  logic [2:0]           err_set;

  // Lowest type code wins; descending scan leaves the lowest set index as the final pick.
  always_comb begin
    merged     = pend | end_vec;
    rpt_vld    = 1'b0;
    rpt_type   = BT_NONE;
    rpt_beats  = '0;
    rpt_onehot = '0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (merged[i]) begin
        rpt_vld       = 1'b1;
        rpt_type      = type_code(i);
        rpt_beats     = end_vec[i] ? end_beats[i] : pend_beats[i];
        rpt_onehot    = '0;
        rpt_onehot[i] = 1'b1;
      end
    end
    pend_nxt = merged & ~rpt_onehot;
  end

  always_comb begin
    err_set               = '0;
    err_set[ERR_CONFLICT] = conflict;
    err_set[ERR_ADDR]     = |aerr_vec;
    err_set[ERR_LEN]      = |lerr_vec;
  end

  logic              qmem_cen, qmem_wen, kmem_cen, kmem_wen, pmem_cen, pmem_wen;
  logic [ADDR_W-1:0] qk_addr, p_addr;
  logic              l0_wr, mac_exec, ofifo_rd_o, sfp_acc, sfp_div;
  logic              burst_done;
  logic [2:0]        burst_type;
  logic [4:0]        burst_beats;
  logic [2:0]        err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qmem_cen    <= 1'b1;
      qmem_wen    <= 1'b1;
      kmem_cen    <= 1'b1;
      kmem_wen    <= 1'b1;
      pmem_cen    <= 1'b1;
      pmem_wen    <= 1'b1;
      qk_addr     <= '0;
      p_addr      <= '0;
      l0_wr       <= 1'b0;
      mac_exec    <= 1'b0;
      ofifo_rd_o  <= 1'b0;
      sfp_acc     <= 1'b0;
      sfp_div     <= 1'b0;
      burst_done  <= 1'b0;
      burst_type  <= '0;
      burst_beats <= '0;
      err         <= '0;
      pend        <= '0;
      for (int i = 0; i < NUM_TYPES; i++) pend_beats[i] <= '0;
    end else begin
      // Read wins on a conflict: the SRAM is enabled but write-disabled.
      qmem_cen    <= ~(q_rd | q_wr);
      qmem_wen    <= ~(q_wr & ~q_rd);
      kmem_cen    <= ~(k_rd | k_wr);
      kmem_wen    <= ~(k_wr & ~k_rd);
      pmem_cen    <= ~(p_rd | p_wr);
      pmem_wen    <= ~(p_wr & ~p_rd);
      qk_addr     <= qk_add;
      p_addr      <= p_add;
      l0_wr       <= inst[B_LOAD];
      mac_exec    <= inst[B_EXECUTE];
      ofifo_rd_o  <= inst[B_OFIFO_RD];
      sfp_acc     <= inst[B_ACC];
      sfp_div     <= inst[B_DIV];
      burst_done  <= rpt_vld;
      burst_type  <= rpt_type;
      burst_beats <= rpt_beats;
      err         <= err | err_set;
      pend        <= pend_nxt;
      for (int i = 0; i < NUM_TYPES; i++) begin
        if (end_vec[i]) pend_beats[i] <= end_beats[i];
      end
    end
  end

  assign bus.qmem_cen    = qmem_cen;
  assign bus.qmem_wen    = qmem_wen;
  assign bus.kmem_cen    = kmem_cen;
  assign bus.kmem_wen    = kmem_wen;
  assign bus.pmem_cen    = pmem_cen;
  assign bus.pmem_wen    = pmem_wen;
  assign bus.qk_addr     = qk_addr;
  assign bus.p_addr      = p_addr;
  assign bus.l0_wr       = l0_wr;
  assign bus.mac_exec    = mac_exec;
  assign bus.ofifo_rd_o  = ofifo_rd_o;
  assign bus.sfp_acc     = sfp_acc;
  assign bus.sfp_div     = sfp_div;
  assign bus.burst_done  = burst_done;
  assign bus.burst_type  = burst_type;
  assign bus.burst_beats = burst_beats;
  assign bus.err         = err;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: strobes, controls, burst reports, error flags and reset abort.
module tb_inst_decoder;

  localparam logic [7:0] EXEC = 8'h80, LOAD = 8'h40, QRD = 8'h20, QWR = 8'h10;
  localparam logic [7:0] KRD  = 8'h08, KWR  = 8'h04, PRD = 8'h02, PWR = 8'h01;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  inst_decoder_if #(.ADDR_W(4)) bus ();

  inst_decoder #(.BURST_LEN(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic [7:0] lo, input int qk, input int p,
                                     input logic [2:0] hi);
    return {hi, 4'(qk), 4'(p), lo};
  endfunction

  // Launch on the current negedge; outputs are read at the next negedge.
  task automatic drive(input logic [18:0] v);
    bus.inst = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    bus.inst = '0;
    #2;
    reset    = 1'b1;
  endtask

  function automatic int strobes();
    return int'({bus.qmem_cen, bus.qmem_wen, bus.kmem_cen, bus.kmem_wen, bus.pmem_cen, bus.pmem_wen});
  endfunction

  function automatic int ctrls();
    return int'({bus.l0_wr, bus.mac_exec, bus.ofifo_rd_o, bus.sfp_acc, bus.sfp_div});
  endfunction

  initial begin
    bus.inst = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_strobes", strobes(), 63);
    check("rst_addr", int'({bus.qk_addr, bus.p_addr}), 0);
    check("rst_ctrl", ctrls(), 0);
    check("rst_report", int'({bus.burst_done, bus.burst_type, bus.burst_beats}), 0);
    check("rst_err", int'(bus.err), 0);
    @(negedge clk);
    reset = 1'b1;

    // Control mapping and address registration
    drive(mk(EXEC | LOAD, 5, 9, 3'b111));
    check("ctrl_on", ctrls(), 31);
    check("ctrl_qk_addr", int'(bus.qk_addr), 5);
    check("ctrl_p_addr", int'(bus.p_addr), 9);
    check("ctrl_strobes", strobes(), 63);
    drive(mk(LOAD, 0, 0, 3'b100));
    check("ctrl_load_div", ctrls(), 5'b10001);
    drive('0);
    check("idle_ctrl", ctrls(), 0);
    check("idle_done", int'(bus.burst_done), 0);

    // Clean 8-beat q write
    for (int i = 0; i < 8; i++) begin
      drive(mk(QWR, i, 0, 3'b000));
      check("qw_strobe", int'({bus.qmem_cen, bus.qmem_wen}), 0);
      check("qw_addr", int'(bus.qk_addr), i);
    end
    check("qw_no_early_done", int'(bus.burst_done), 0);
    drive('0);
    check("qw_strobe_off", int'({bus.qmem_cen, bus.qmem_wen}), 3);
    check("qw_done", int'(bus.burst_done), 1);
    check("qw_type", int'(bus.burst_type), 1);
    check("qw_beats", int'(bus.burst_beats), 8);
    check("qw_err", int'(bus.err), 0);
    drive('0);
    check("qw_done_pulse", int'(bus.burst_done), 0);
    do_reset();

    // Short k write: length error, sticky
    for (int i = 0; i < 7; i++) drive(mk(KWR, i, 0, 3'b000));
    drive('0);
    check("kw_done", int'(bus.burst_done), 1);
    check("kw_type", int'(bus.burst_type), 2);
    check("kw_beats", int'(bus.burst_beats), 7);
    check("kw_err", int'(bus.err), 4);
    drive('0);
    drive('0);
    check("kw_err_sticky", int'(bus.err), 4);
    do_reset();

    // q read with address skip
    drive(mk(QRD, 0, 0, 3'b000));
    drive(mk(QRD, 1, 0, 3'b000));
    check("qr_err_before", int'(bus.err), 0);
    drive(mk(QRD, 3, 0, 3'b000));
    check("qr_err_addr", int'(bus.err), 2);
    check("qr_strobe", int'({bus.qmem_cen, bus.qmem_wen}), 1);
    drive('0);
    check("qr_type", int'(bus.burst_type), 4);
    check("qr_beats", int'(bus.burst_beats), 3);
    check("qr_no_len", int'(bus.err), 2);
    do_reset();

    // p read/write conflict
    drive(mk(PRD | PWR, 0, 0, 3'b000));
    check("cf_strobe", int'({bus.pmem_cen, bus.pmem_wen}), 1);
    check("cf_err", int'(bus.err), 1);
    drive('0);
    check("cf_done", int'(bus.burst_done), 1);
    check("cf_type", int'(bus.burst_type), 5);
    check("cf_beats", int'(bus.burst_beats), 1);
    check("cf_err_len", int'(bus.err), 5);
    do_reset();

    // Reset mid p-write burst, then a clean burst
    for (int i = 0; i < 4; i++) drive(mk(PWR, 0, i, 3'b000));
    check("pw_active", int'(bus.pmem_cen), 0);
    bus.inst = mk(PWR, 0, 4, 3'b000);
    reset = 1'b0;
    #1;
    check("abort_strobes", strobes(), 63);
    check("abort_err", int'(bus.err), 0);
    check("abort_done", int'(bus.burst_done), 0);
    bus.inst = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_no_done", int'(bus.burst_done), 0);
    for (int i = 0; i < 8; i++) drive(mk(PWR, 0, i, 3'b000));
    drive('0);
    check("pw2_done", int'(bus.burst_done), 1);
    check("pw2_type", int'(bus.burst_type), 5);
    check("pw2_beats", int'(bus.burst_beats), 8);
    check("pw2_err", int'(bus.err), 0);
    do_reset();

    // q and k reads ending together
    for (int i = 0; i < 3; i++) drive(mk(QRD | KRD, i, 0, 3'b000));
    drive('0);
    check("sim_done1", int'(bus.burst_done), 1);
    check("sim_type1", int'(bus.burst_type), 3);
    check("sim_beats1", int'(bus.burst_beats), 3);
    drive('0);
    check("sim_done2", int'(bus.burst_done), 1);
    check("sim_type2", int'(bus.burst_type), 4);
    check("sim_beats2", int'(bus.burst_beats), 3);
    drive('0);
    check("sim_done3", int'(bus.burst_done), 0);
    check("sim_err", int'(bus.err), 0);
    do_reset();

    // Long read: address wraps legally, beat count saturates
    for (int i = 0; i < 33; i++) drive(mk(QRD, i % 16, 0, 3'b000));
    drive('0);
    check("wrap_type", int'(bus.burst_type), 4);
    check("wrap_beats", int'(bus.burst_beats), 31);
    check("wrap_err", int'(bus.err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
